// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl
// Tag-lookup controller for a direct-mapped, write-through, no-write-allocate
// cache. The tag RAM is external and synchronous-read. On reset the RAM is
// cleared by a flush sweep before any CPU access is accepted.
//
// Ports
//   clock, reset_n                 clock and asynchronous active-low reset
//   cpu_req/cpu_wr/cpu_addr        CPU request, accepted when cpu_ready
//   cpu_ready                      controller idle and able to accept
//   resp_valid/resp_hit            one-cycle completion pulse and hit flag
//   mem_req/mem_we/mem_ack         backing-memory handshake
//   tag_addr/tag_din/tag_we        tag RAM address, write data, write enable
//   tag_dout                       tag RAM read data (one cycle after address)
//   hit_cnt/miss_cnt               saturating access statistics
//
// state   | meaning
// --------+-----------------------------------------------------------
// FLUSH   | clear every tag RAM entry, index 0 upward
// IDLE    | ready; tag RAM addressed by the incoming CPU index
// COMPARE | tag RAM data valid, hit/miss decided
// FILL    | read miss: fetch line from memory, wait for mem_ack
// UPDATE  | install {valid, tag} at the latched index
// WTHRU   | write: forward to memory, wait for mem_ack
// DONE    | response pulse, statistics update

module cache_tag_ctrl #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 14,
    parameter int OWIDTH = 2,
    localparam int TWIDTH = DWIDTH - 1,
    localparam int CWIDTH = TWIDTH + AWIDTH + OWIDTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [CWIDTH-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [AWIDTH-1:0] tag_addr,
    output logic [DWIDTH-1:0] tag_din,
    output logic              tag_we,
    input  logic [DWIDTH-1:0] tag_dout,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    typedef enum logic [2:0] {
        S_FLUSH, S_IDLE, S_COMPARE, S_FILL, S_UPDATE, S_WTHRU, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_flush_cnt;
    logic                r_armed;
    logic [TWIDTH-1:0]   r_tag;
    logic [AWIDTH-1:0]   r_index;
    logic                r_wr;
    logic                r_hit;
    logic [15:0]         r_hit_cnt;
    logic [15:0]         r_miss_cnt;

    logic [TWIDTH-1:0]   w_cpu_tag;
    logic [AWIDTH-1:0]   w_cpu_index;
    logic                w_hit;
    logic                w_flush_we;
    logic                w_accept;
    logic                w_unused_offset;

    assign w_cpu_tag   = cpu_addr[CWIDTH-1 -: TWIDTH];
    assign w_cpu_index = cpu_addr[OWIDTH +: AWIDTH];
    // Byte offset plays no part in the tag lookup.
    assign w_unused_offset = ^cpu_addr[OWIDTH-1:0];

    assign w_hit    = tag_dout[DWIDTH-1] & (tag_dout[DWIDTH-2:0] == r_tag);
    // The sweep starts one edge after reset release, so tag_we stays low
    // while reset is held even though the state is already FLUSH.
    assign w_flush_we = (r_state == S_FLUSH) & r_armed;
    assign w_accept   = (r_state == S_IDLE) & cpu_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cpu_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        tag_we      = 1'b0;
        tag_addr    = r_index;
        tag_din     = '0;
        case (r_state)
            S_FLUSH: begin
                tag_addr = r_flush_cnt;
                tag_we   = w_flush_we;
                if (w_flush_we && (r_flush_cnt == '1)) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                cpu_ready = 1'b1;
                tag_addr  = w_cpu_index;
                if (cpu_req) w_state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
                if (r_wr)       w_state_nxt = S_WTHRU;
                else if (w_hit) w_state_nxt = S_DONE;
                else            w_state_nxt = S_FILL;
            end
            S_FILL: begin
                mem_req = 1'b1;
                if (mem_ack) w_state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                tag_we      = 1'b1;
                tag_din     = {1'b1, r_tag};
                w_state_nxt = S_DONE;
            end
            S_WTHRU: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                resp_valid  = 1'b1;
                resp_hit    = r_hit;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_FLUSH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
            r_tag       <= '0;
            r_index     <= '0;
            r_wr        <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_armed <= 1'b1;
            // Wraps back to 0 after the last entry, ready for the next flush.
            if (w_flush_we) r_flush_cnt <= r_flush_cnt + 1'b1;
            if (w_accept) begin
                r_tag   <= w_cpu_tag;
                r_index <= w_cpu_index;
                r_wr    <= cpu_wr;
            end
            if (r_state == S_COMPARE) r_hit <= w_hit;
            if (r_state == S_DONE) begin
                if (r_hit) begin
                    if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
                end else begin
                    if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
                end
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule
